// File: rtl/spi_piso_if.sv
// ----------------------------------------------------------------------------
// spi_piso_if
//
// Transmit-side bus between the SPI slave control logic and the spi_piso
// parallel-in/serial-out shifter.
//
// Parameters:
//   DATA_W   transmit word width
//   CNT_W    width of the frame slot counter
//
// Signals:
//   tx_valid  transmit enable, held high for the whole frame
//   counter   slot index from the control FSM (0 = MSB slot)
//   tx_data   parallel word to transmit
//   dout      serial data towards MISO (registered in the shifter)
//   tx_done   one-cycle pulse while the LSB is on dout
//
// Modports:
//   master  control side: drives tx_valid/counter/tx_data, observes dout/tx_done
//   slave   shifter side: observes tx_valid/counter/tx_data, drives dout/tx_done
// ----------------------------------------------------------------------------
interface spi_piso_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              tx_valid;
    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] tx_data;
    logic              dout;
    logic              tx_done;

    modport master (
        output tx_valid,
        output counter,
        output tx_data,
        input  dout,
        input  tx_done
    );

    modport slave (
        input  tx_valid,
        input  counter,
        input  tx_data,
        output dout,
        output tx_done
    );
endinterface : spi_piso_if

// File: rtl/spi_piso.sv
// ----------------------------------------------------------------------------
// spi_piso
//
// Parallel-in/serial-out transmit shifter for the SPI slave. Converts a
// DATA_W-bit word into an MSB-first serial stream on dout, one bit per clock.
// The bit slot is chosen by an external counter (slot k drives bit
// DATA_W-1-k); counter values >= DATA_W are guard slots that drive 0.
// dout and tx_done are registered, so results appear one clock after the
// inputs are sampled.
//
// Parameters:
//   DATA_W   transmit word width (>= 2)
//   CNT_W    counter width (2**CNT_W > DATA_W)
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   spi_piso_if.slave (tx_valid, counter, tx_data in; dout, tx_done out)
//
// Build option:
//   PISO_LATCH_EN  when defined, tx_data is captured into a holding register
//                  in slot 0 and slots 1..DATA_W-1 read that register, so the
//                  frame in flight ignores later tx_data changes. When not
//                  defined, every slot reads live tx_data.
// ----------------------------------------------------------------------------
module spi_piso #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst,
    spi_piso_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DATA_W - 1);

    logic              dout_q;
    logic              tx_done_q;
    logic              in_frame;
    logic              last_slot;
    logic              sel_bit;
    logic [DATA_W-1:0] word_sel;

    // Guard slots (counter > LAST_SLOT) fall outside the frame.
    assign in_frame  = (bus.counter <= LAST_SLOT);
    assign last_slot = (bus.counter == LAST_SLOT);

`ifdef PISO_LATCH_EN
    logic [DATA_W-1:0] hold_q;

    // Slot 0 always sees the live word; later slots see the captured copy.
    assign word_sel = (bus.counter == '0) ? bus.tx_data : hold_q;

    // NOTE: the holding register is reset because it is read by slots 1..N
    // of a frame that resumes after reset without passing through slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (bus.tx_valid && (bus.counter == '0)) begin
            hold_q <= bus.tx_data;
        end
    end
`else
    assign word_sel = bus.tx_data;
`endif

    // MSB-first slot-to-bit mapping, written as a compare per slot so no
    // index narrower or wider than the word is ever formed.
    // NOTE: sel_bit gets a default before the loop so no latch is inferred
    // for counter values that match no slot.
    always_comb begin
        sel_bit = 1'b0;
        for (int k = 0; k < DATA_W; k++) begin
            if (bus.counter == CNT_W'(k)) begin
                sel_bit = word_sel[DATA_W-1-k];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else if (bus.tx_valid && in_frame) begin
            dout_q    <= sel_bit;
            tx_done_q <= last_slot;
        end else begin
            // Idle, abandoned frame or guard slot: line held low, no done.
            dout_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end
    end

    assign bus.dout    = dout_q;
    assign bus.tx_done = tx_done_q;

endmodule : spi_piso

// File: tb/tb_spi_piso.sv
// ----------------------------------------------------------------------------
// tb_spi_piso
//
// Directed self-checking bench for spi_piso (DATA_W=8, CNT_W=4). Inputs are
// changed 1 ns after a rising edge; outputs are checked 1 ns after the next
// rising edge, i.e. the expected value is the response to the vector just
// applied. Expected bit streams are hand-written per vector.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_piso;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    spi_piso_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    spi_piso #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one vector, clock it in, and land 1 ns after the edge.
    task automatic step(input logic r, input logic v, input logic [CNT_W-1:0] c,
                        input logic [DATA_W-1:0] d);
        rst          = r;
        bus.tx_valid = v;
        bus.counter  = c;
        bus.tx_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Full frame, counter 0..7, checking each bit and the done pulse.
    task automatic run_frame(input string tag, input logic [DATA_W-1:0] d,
                             input logic [DATA_W-1:0] exp_seq);
        for (int k = 0; k < DATA_W; k++) begin
            step(1'b0, 1'b1, CNT_W'(k), d);
            check($sformatf("%s dout slot %0d", tag, k), 32'(bus.dout), 32'(exp_seq[DATA_W-1-k]));
            check($sformatf("%s done slot %0d", tag, k), 32'(bus.tx_done), 32'(k == DATA_W-1));
        end
    endtask

    initial begin
        logic [DATA_W-1:0] mid_exp;
        logic [DATA_W-1:0] seq;
        logic [DATA_W-1:0] cur;
        logic              resume_bit;

        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.counter  = '0;
        bus.tx_data  = '0;

        // Reset wins over tx_valid with an all-ones word.
        step(1'b1, 1'b1, 4'd0, 8'hFF);
        check("reset dout", 32'(bus.dout), 32'd0);
        check("reset done", 32'(bus.tx_done), 32'd0);
        step(1'b1, 1'b1, 4'd1, 8'hFF);
        check("reset dout 2", 32'(bus.dout), 32'd0);

        // Basic frame: A5 -> 1,0,1,0,0,1,0,1.
        seq = 8'b1010_0101;
        run_frame("basic A5", 8'hA5, seq);

        // Guard slots 8..10 drive 0 with no done, then wrap into 3C.
        for (int g = 8; g <= 10; g++) begin
            step(1'b0, 1'b1, CNT_W'(g), 8'hFF);
            check($sformatf("guard dout %0d", g), 32'(bus.dout), 32'd0);
            check($sformatf("guard done %0d", g), 32'(bus.tx_done), 32'd0);
        end
        seq = 8'b0011_1100;
        run_frame("wrap 3C", 8'h3C, seq);

        // Back-to-back frame with no idle cycle: C3 -> 1,1,0,0,0,0,1,1.
        seq = 8'b1100_0011;
        run_frame("b2b C3", 8'hC3, seq);

        // Idle: tx_valid low with random data and counter.
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, CNT_W'($urandom_range(0, 15)), DATA_W'($urandom));
            check("idle dout", 32'(bus.dout), 32'd0);
            check("idle done", 32'(bus.tx_done), 32'd0);
        end

        // Mid-frame data change: F0 in slots 0..1, 0F from slot 2.
`ifdef PISO_LATCH_EN
        mid_exp = 8'b1111_0000;
`else
        mid_exp = 8'b1100_1111;
`endif
        for (int k = 0; k < DATA_W; k++) begin
            cur = (k < 2) ? 8'hF0 : 8'h0F;
            step(1'b0, 1'b1, CNT_W'(k), cur);
            check($sformatf("midchg dout slot %0d", k), 32'(bus.dout), 32'(mid_exp[DATA_W-1-k]));
            check($sformatf("midchg done slot %0d", k), 32'(bus.tx_done), 32'(k == DATA_W-1));
        end

        // Jumping counter: 5A captured at slot 0, then slots 6,2,3,15,7.
        step(1'b0, 1'b1, 4'd0, 8'h5A);
        check("jump slot0", 32'(bus.dout), 32'd0);
        step(1'b0, 1'b1, 4'd6, 8'h5A);
        check("jump slot6", 32'(bus.dout), 32'd1);
        step(1'b0, 1'b1, 4'd2, 8'h5A);
        check("jump slot2", 32'(bus.dout), 32'd0);
        step(1'b0, 1'b1, 4'd3, 8'h5A);
        check("jump slot3", 32'(bus.dout), 32'd1);
        step(1'b0, 1'b1, 4'd15, 8'h5A);
        check("jump slot15 dout", 32'(bus.dout), 32'd0);
        check("jump slot15 done", 32'(bus.tx_done), 32'd0);
        step(1'b0, 1'b1, 4'd7, 8'h5A);
        check("jump slot7 dout", 32'(bus.dout), 32'd0);
        check("jump slot7 done", 32'(bus.tx_done), 32'd1);

        // Abort: FF frame, tx_valid dropped at slot 4 and kept low to slot 7.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, CNT_W'(k), 8'hFF);
            check($sformatf("abort pre dout %0d", k), 32'(bus.dout), 32'd1);
        end
        for (int k = 4; k < DATA_W; k++) begin
            step(1'b0, 1'b0, CNT_W'(k), 8'hFF);
            check($sformatf("abort dout %0d", k), 32'(bus.dout), 32'd0);
            check($sformatf("abort done %0d", k), 32'(bus.tx_done), 32'd0);
        end

        // Reset mid-frame at slot 5, then resume at slots 6,7. The resumed
        // slots read the cleared holding register when latching is enabled.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, CNT_W'(k), 8'hFF);
            check($sformatf("rstmid pre dout %0d", k), 32'(bus.dout), 32'd1);
        end
        step(1'b1, 1'b1, 4'd5, 8'hFF);
        check("rstmid dout", 32'(bus.dout), 32'd0);
        check("rstmid done", 32'(bus.tx_done), 32'd0);
`ifdef PISO_LATCH_EN
        resume_bit = 1'b0;
`else
        resume_bit = 1'b1;
`endif
        step(1'b0, 1'b1, 4'd6, 8'hFF);
        check("resume slot6 dout", 32'(bus.dout), 32'(resume_bit));
        check("resume slot6 done", 32'(bus.tx_done), 32'd0);
        step(1'b0, 1'b1, 4'd7, 8'hFF);
        check("resume slot7 dout", 32'(bus.dout), 32'(resume_bit));
        check("resume slot7 done", 32'(bus.tx_done), 32'd1);

        // tx_valid deasserted exactly on the last slot: no done pulse.
        for (int k = 0; k < DATA_W-1; k++) begin
            step(1'b0, 1'b1, CNT_W'(k), 8'hFF);
        end
        check("lastdrop pre dout", 32'(bus.dout), 32'd1);
        step(1'b0, 1'b0, 4'd7, 8'hFF);
        check("lastdrop dout", 32'(bus.dout), 32'd0);
        check("lastdrop done", 32'(bus.tx_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_spi_piso
